bcd_conv_sched: RTL

Controller and two-port scheduler for the shift-register binary-to-BCD conversion chain used by the display path. It accepts 36-bit conversion requests from two requesters and arbitrates between them round-robin. It sequences the chain through load, 36 shift cycles and capture, then returns the 9-digit BCD result tagged with the requester id. Inputs above 999,999,999 bypass the chain and return a saturated result with an overflow flag.

---
 rtl/bcd_conv_pkg.sv | 28 ++
 rtl/bcd_conv_sched_rr_arbiter2.sv | 51 +++++
 rtl/bcd_conv_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bcd_conv_pkg.sv
// Shared definitions for the binary-to-BCD conversion scheduler.
// Holds the FSM state enum, operand/result widths, the saturation pattern,
// the shift counter width and a helper for the overflow compare.
package bcd_conv_pkg;

    localparam int DATA_W = 36;
    localparam int DIGITS = 9;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic [DATA_W-1:0] MAX_VAL    = 36'd999_999_999;
    localparam logic [BCD_W-1:0]  SAT_BCD    = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // True when the operand cannot be represented in DIGITS decimal digits.
    function automatic logic operand_overflows(input logic [DATA_W-1:0] value);
        return (value > MAX_VAL);
    endfunction

endpackage

// File: rtl/bcd_conv_sched_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   req_i      request levels from requesters 0 and 1
//   advance_i  commit the current grant and rotate priority
//   grant_o    one-hot grant (combinational from req_i and priority)
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    // pri_q names the requester that wins a tie; it is always the one not
    // granted last, so reset value 0 favours requester 0.
    logic pri_q;
    logic pri_d;
    logic [1:0] grant_s;

    // Grant selection and priority rotation.
    always_comb begin
        grant_s = 2'b00;
        pri_d   = pri_q;
        case (req_i)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = pri_q ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
        if (advance_i && (grant_s != 2'b00)) begin
            // Winner 0 hands priority to 1 and vice versa.
            pri_d = grant_s[0];
        end else begin
            pri_d = pri_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pri_q <= 1'b0;
        end else begin
            pri_q <= pri_d;
        end
    end

    assign grant_o = grant_s;

endmodule

// File: rtl/bcd_conv_sched.sv
// Scheduler and controller for the shift-register binary-to-BCD chain.
// Two requesters are arbitrated round-robin; the winner's operand is loaded
// into the chain, shifted DATA_W times and the BCD digits captured. Operands
// above MAX_VAL skip the chain and return all-nines with res_ovf_o set.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_i, data0_i, data1_i request levels and operands
//   ack_o                   one-hot grant pulse (issued in IDLE)
//   dp_data_o, dp_load_o,
//   dp_shift_o, dp_bcd_i    chain control and chain digits
//   res_bcd_o, res_id_o,
//   res_ovf_o, res_valid_o  result register and its valid pulse
//   busy_o                  high outside IDLE
module bcd_conv_sched
    import bcd_conv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        req_i,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    output logic [1:0]        ack_o,
    output logic [DATA_W-1:0] dp_data_o,
    output logic              dp_load_o,
    output logic              dp_shift_o,
    input  logic [BCD_W-1:0]  dp_bcd_i,
    output logic [BCD_W-1:0]  res_bcd_o,
    output logic              res_id_o,
    output logic              res_ovf_o,
    output logic              res_valid_o,
    output logic              busy_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  op_q, op_d;
    logic               id_q, id_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   res_bcd_q, res_bcd_d;
    logic               res_id_q, res_id_d;
    logic               res_ovf_q, res_ovf_d;
    logic               dp_load_q, dp_shift_q, busy_q, res_valid_q;

    logic [1:0]         grant_s;
    logic               in_idle_s;
    logic               advance_s;
    logic [DATA_W-1:0]  sel_data_s;

    assign in_idle_s  = (state_q == ST_IDLE);
    assign advance_s  = in_idle_s && (req_i != 2'b00);
    assign sel_data_s = grant_s[1] ? data1_i : data0_i;

    rr_arbiter2 u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .advance_i (advance_s),
        .grant_o   (grant_s)
    );

    // Next-state, counter, operand latch and result register logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        id_d      = id_q;
        ovf_d     = ovf_q;
        res_bcd_d = res_bcd_q;
        res_id_d  = res_id_q;
        res_ovf_d = res_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i != 2'b00) begin
                    op_d    = sel_data_s;
                    id_d    = grant_s[1];
                    ovf_d   = operand_overflows(sel_data_s);
                    state_d = operand_overflows(sel_data_s) ? ST_CAPTURE : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == LAST_SHIFT) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                res_bcd_d = ovf_q ? SAT_BCD : dp_bcd_i;
                res_ovf_d = ovf_q;
                res_id_d  = id_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered strobes. Strobes decode the next state
    // so they are high during the cycle the FSM spends in that state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            ovf_q       <= 1'b0;
            res_bcd_q   <= '0;
            res_id_q    <= 1'b0;
            res_ovf_q   <= 1'b0;
            dp_load_q   <= 1'b0;
            dp_shift_q  <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            id_q        <= id_d;
            ovf_q       <= ovf_d;
            res_bcd_q   <= res_bcd_d;
            res_id_q    <= res_id_d;
            res_ovf_q   <= res_ovf_d;
            dp_load_q   <= (state_d == ST_LOAD);
            dp_shift_q  <= (state_d == ST_SHIFT);
            busy_q      <= (state_d != ST_IDLE);
            res_valid_q <= (state_d == ST_DONE);
        end
    end

    // The grant is only visible while IDLE is actually sampling requests.
    assign ack_o       = in_idle_s ? grant_s : 2'b00;
    assign dp_data_o   = op_q;
    assign dp_load_o   = dp_load_q;
    assign dp_shift_o  = dp_shift_q;
    assign res_bcd_o   = res_bcd_q;
    assign res_id_o    = res_id_q;
    assign res_ovf_o   = res_ovf_q;
    assign res_valid_o = res_valid_q;
    assign busy_o      = busy_q;

endmodule
